// File: rtl/sseg_pkg.sv
// sseg_pkg: seven-segment patterns (active low, {g..a}) and anode selects.
package sseg_pkg;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [1:0] AN_ONES   = 2'b10;
  localparam logic [1:0] AN_TENS   = 2'b01;
  localparam logic [1:0] AN_OFF    = 2'b11;
endpackage

// File: rtl/sseg_decode.sv
// sseg_decode: BCD digit to active-low segment pattern, blank above 9.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);
  always_comb begin
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/cnt_sseg_driver.sv
// cnt_sseg_driver: 2-digit multiplexed display of a 4-bit count, direction on dp.
module cnt_sseg_driver
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  input  logic       up_down,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  logic [CW-1:0] r_ctr;
  logic          r_sel;
  logic [3:0]    r_disp_val;
  logic          r_disp_dir;
  logic [1:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          w_tick;
  logic          w_tens;
  logic [3:0]    w_ones;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;
  assign w_tick  = (r_ctr == CW'(REFRESH_DIV - 1));
  assign w_tens  = (r_disp_val >= 4'd10);
  assign w_ones  = w_tens ? r_disp_val - 4'd10 : r_disp_val;
  assign w_digit = r_sel ? {3'b000, w_tens} : w_ones;
  sseg_decode u_dec (.i_digit(w_digit), .o_seg(w_seg));
  // Snapshot only at the tens->ones boundary so a frame never mixes two values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr      <= '0;
      r_sel      <= 1'b0;
      r_disp_val <= 4'd0;
      r_disp_dir <= 1'b0;
      r_an       <= AN_OFF;
      r_seg      <= SEG_BLANK;
      r_dp       <= 1'b1;
    end else begin
      r_ctr      <= w_tick ? '0 : r_ctr + 1'b1;
      r_sel      <= w_tick ? ~r_sel : r_sel;
      r_disp_val <= (w_tick && r_sel) ? count : r_disp_val;
      r_disp_dir <= (w_tick && r_sel) ? up_down : r_disp_dir;
      r_an       <= r_sel ? AN_TENS : AN_ONES;
      r_seg      <= (r_sel && BLANK_LZ && !w_tens) ? SEG_BLANK : w_seg;
      r_dp       <= r_sel | ~r_disp_dir;
    end
  end
  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;
endmodule

// File: tb/tb_cnt_sseg_driver.sv
// tb_cnt_sseg_driver: directed checks of scan, snapshot, blanking, wrap and reset.
module tb_cnt_sseg_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count = 4'd0;
  logic       up_down = 1'b0;
  logic [1:0] an, an0;
  logic [6:0] seg, seg0;
  logic       dp, dp0;
  int total = 0;
  int bad = 0;
  int e = 0;

  cnt_sseg_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .count(count), .up_down(up_down), .an(an), .seg(seg), .dp(dp));
  cnt_sseg_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .count(count), .up_down(up_down), .an(an0), .seg(seg0), .dp(dp0));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic go(input int k);
    while (e < k) tick();
  endtask

  task automatic test_reset();
    count = 4'd9; up_down = 1'b0; rst = 1'b1;
    tick(); tick();
    total++;
    if ({an, seg, dp} !== {2'b11, 7'b1111111, 1'b1}) begin
      bad++; $display("FAIL reset_dark got %b req %b", {an, seg, dp}, {2'b11, 7'b1111111, 1'b1});
    end
    rst = 1'b0; e = 0;
    tick();
    total++;
    if ({an, seg, dp} !== {2'b10, 7'b1000000, 1'b1}) begin
      bad++; $display("FAIL first_frame_ones got %b req %b", {an, seg, dp}, {2'b10, 7'b1000000, 1'b1});
    end
    count = 4'd7; up_down = 1'b1;
    go(5);
    total++;
    if ({an, seg, dp} !== {2'b01, 7'b1111111, 1'b1}) begin
      bad++; $display("FAIL first_frame_tens got %b req %b", {an, seg, dp}, {2'b01, 7'b1111111, 1'b1});
    end
    total++;
    if ({an0, seg0, dp0} !== {2'b01, 7'b1000000, 1'b1}) begin
      bad++; $display("FAIL first_frame_tens_lz0 got %b req %b", {an0, seg0, dp0}, {2'b01, 7'b1000000, 1'b1});
    end
  endtask

  task automatic test_seven_up();
    go(9);
    total++;
    if ({an, seg, dp} !== {2'b10, 7'b1111000, 1'b0}) begin
      bad++; $display("FAIL seven_ones got %b req %b", {an, seg, dp}, {2'b10, 7'b1111000, 1'b0});
    end
    go(12);
    total++;
    if ({an, seg, dp} !== {2'b10, 7'b1111000, 1'b0}) begin
      bad++; $display("FAIL seven_ones_hold got %b req %b", {an, seg, dp}, {2'b10, 7'b1111000, 1'b0});
    end
    go(13);
    total++;
    if ({an, seg, dp} !== {2'b01, 7'b1111111, 1'b1}) begin
      bad++; $display("FAIL seven_tens_blank got %b req %b", {an, seg, dp}, {2'b01, 7'b1111111, 1'b1});
    end
    count = 4'd12; up_down = 1'b0;
  endtask

  task automatic test_twelve_down();
    go(17);
    total++;
    if ({an, seg, dp} !== {2'b10, 7'b0100100, 1'b1}) begin
      bad++; $display("FAIL twelve_ones got %b req %b", {an, seg, dp}, {2'b10, 7'b0100100, 1'b1});
    end
    go(21);
    total++;
    if ({an, seg, dp} !== {2'b01, 7'b1111001, 1'b1}) begin
      bad++; $display("FAIL twelve_tens got %b req %b", {an, seg, dp}, {2'b01, 7'b1111001, 1'b1});
    end
  endtask

  task automatic test_change_mid_frame();
    count = 4'd5;
    go(24);
    total++;
    if ({an, seg} !== {2'b01, 7'b1111001}) begin
      bad++; $display("FAIL frame_holds_12 got %b req %b", {an, seg}, {2'b01, 7'b1111001});
    end
    go(25);
    total++;
    if ({an, seg, dp} !== {2'b10, 7'b0010010, 1'b1}) begin
      bad++; $display("FAIL five_ones got %b req %b", {an, seg, dp}, {2'b10, 7'b0010010, 1'b1});
    end
    go(29);
    total++;
    if ({an, seg} !== {2'b01, 7'b1111111}) begin
      bad++; $display("FAIL five_tens_blank got %b req %b", {an, seg}, {2'b01, 7'b1111111});
    end
  endtask

  task automatic test_wrap();
    count = 4'd15; up_down = 1'b1;
    go(33);
    total++;
    if ({an, seg, dp} !== {2'b10, 7'b0010010, 1'b0}) begin
      bad++; $display("FAIL fifteen_ones got %b req %b", {an, seg, dp}, {2'b10, 7'b0010010, 1'b0});
    end
    go(37);
    total++;
    if ({an, seg} !== {2'b01, 7'b1111001}) begin
      bad++; $display("FAIL fifteen_tens got %b req %b", {an, seg}, {2'b01, 7'b1111001});
    end
    count = 4'd0;
    go(41);
    total++;
    if ({an, seg, dp} !== {2'b10, 7'b1000000, 1'b0}) begin
      bad++; $display("FAIL zero_ones got %b req %b", {an, seg, dp}, {2'b10, 7'b1000000, 1'b0});
    end
    go(45);
    total++;
    if ({an, seg} !== {2'b01, 7'b1111111}) begin
      bad++; $display("FAIL zero_tens_blank got %b req %b", {an, seg}, {2'b01, 7'b1111111});
    end
  endtask

  task automatic test_leading_zero();
    count = 4'd3;
    go(49);
    total++;
    if ({an0, seg0} !== {2'b10, 7'b0110000}) begin
      bad++; $display("FAIL three_ones_lz0 got %b req %b", {an0, seg0}, {2'b10, 7'b0110000});
    end
    go(53);
    total++;
    if ({an0, seg0, dp0} !== {2'b01, 7'b1000000, 1'b1}) begin
      bad++; $display("FAIL three_tens_lz0 got %b req %b", {an0, seg0, dp0}, {2'b01, 7'b1000000, 1'b1});
    end
    total++;
    if (seg !== 7'b1111111) begin
      bad++; $display("FAIL three_tens_lz1 got %b req %b", seg, 7'b1111111);
    end
  endtask

  task automatic test_rst_mid();
    go(54);
    rst = 1'b1;
    tick();
    total++;
    if ({an, seg, dp} !== {2'b11, 7'b1111111, 1'b1}) begin
      bad++; $display("FAIL mid_reset_dark got %b req %b", {an, seg, dp}, {2'b11, 7'b1111111, 1'b1});
    end
    rst = 1'b0; e = 0;
    tick();
    total++;
    if ({an, seg, dp} !== {2'b10, 7'b1000000, 1'b1}) begin
      bad++; $display("FAIL post_reset_ones got %b req %b", {an, seg, dp}, {2'b10, 7'b1000000, 1'b1});
    end
    go(5);
    total++;
    if ({an, seg} !== {2'b01, 7'b1111111}) begin
      bad++; $display("FAIL post_reset_tens got %b req %b", {an, seg}, {2'b01, 7'b1111111});
    end
    go(9);
    total++;
    if ({an, seg, dp} !== {2'b10, 7'b0110000, 1'b0}) begin
      bad++; $display("FAIL post_reset_snapshot got %b req %b", {an, seg, dp}, {2'b10, 7'b0110000, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (an !== ((((e - 1) / 4) % 2 == 1) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL scan_anode e=%0d got %b", e, an);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seven_up();
    test_twelve_down();
    test_change_mid_frame();
    test_wrap();
    test_leading_zero();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
